// File: rtl/discrete_input_receivers.sv
// discrete_input_receivers
//
// Receive side of the triple-redundant discrete interface. Each of the N
// input bits arrives on three channels (A/B/C) that are asynchronous to
// SIM_CLK. Every bit goes through three steps:
//   - each channel passes through a two-flop synchroniser;
//   - the three synchronised channels are majority-voted;
//   - the voted bit is debounced into filt_reg.
// The computer reads the filtered word with a 4-phase RD_REQ/RD_ACK
// handshake. DIR_CHG is sticky and reports that filt_reg moved since the
// last capture.
//
// Optional build macro: DISC_MISCOMPARE_EN
//   Defined   : builds per-bit channel-miscompare counters. MISCMP is sticky
//               and is cleared by MISCMP_CLR.
//   Undefined : MISCMP is tied to 0 and MISCMP_CLR is ignored.
//
// Ports:
//   SIM_CLK     in   system clock
//   SIM_RST     in   asynchronous active-high reset
//   DI_A/B/C    in   [N] discrete inputs, three redundant channels
//   RD_REQ      in   read request (level, 4-phase)
//   DIR         out  [N] captured discrete input register
//   RD_ACK      out  read acknowledge (registered)
//   DIR_CHG     out  sticky: filtered word changed since last capture
//   MISCMP      out  [N] sticky per-bit channel miscompare
//   MISCMP_CLR  in   clears MISCMP
module discrete_input_receivers #(
    parameter int N            = 4,
    parameter int DEBOUNCE     = 4,
    parameter int MISCMP_LIMIT = 8
) (
    input  logic         SIM_CLK,
    input  logic         SIM_RST,
    input  logic [N-1:0] DI_A,
    input  logic [N-1:0] DI_B,
    input  logic [N-1:0] DI_C,
    input  logic         RD_REQ,
    output logic [N-1:0] DIR,
    output logic         RD_ACK,
    output logic         DIR_CHG,
    output logic [N-1:0] MISCMP,
    input  logic         MISCMP_CLR
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    // Two-flop synchronisers, one pair per channel.
    logic [N-1:0] s1_a_reg, s1_b_reg, s1_c_reg;
    logic [N-1:0] s2_a_reg, s2_b_reg, s2_c_reg;
    logic [N-1:0] vote;
    logic [N-1:0] filt_reg;
    logic [N-1:0] filt_toggle;

    state_t       state_reg, state_next;
    logic         capture;
    logic         rd_ack_next;
    logic         rd_ack_reg;
    logic [N-1:0] dir_reg;
    logic         dir_chg_reg;

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            s1_a_reg <= '0;
            s1_b_reg <= '0;
            s1_c_reg <= '0;
            s2_a_reg <= '0;
            s2_b_reg <= '0;
            s2_c_reg <= '0;
        end else begin
            s1_a_reg <= DI_A;
            s1_b_reg <= DI_B;
            s1_c_reg <= DI_C;
            s2_a_reg <= s1_a_reg;
            s2_b_reg <= s1_b_reg;
            s2_c_reg <= s1_c_reg;
        end
    end

    // 2-of-3 majority. A single faulty channel can never move the vote.
    assign vote = (s2_a_reg & s2_b_reg) | (s2_a_reg & s2_c_reg) | (s2_b_reg & s2_c_reg);

    // Debounce. The counter tracks how many consecutive samples of the vote
    // have disagreed with filt. When the next disagreeing sample would make
    // that count DEBOUNCE, the bit flips on that edge instead.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_deb
            logic [DW-1:0] cnt_reg;
            logic          differ;

            assign differ          = vote[gi] ^ filt_reg[gi];
            assign filt_toggle[gi] = differ && (cnt_reg == DW'(DEBOUNCE - 1));

            always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
                if (SIM_RST) begin
                    cnt_reg <= '0;
                end else if (!differ || filt_toggle[gi]) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            filt_reg <= '0;
        end else begin
            filt_reg <= filt_reg ^ filt_toggle;
        end
    end

    // Read handshake FSM: state register.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read handshake FSM: next state. Leaving ACK requires RD_REQ to be seen
    // low, so one request level yields exactly one capture.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (RD_REQ)  state_next = ACK;
            ACK:     if (!RD_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read handshake FSM: outputs.
    always_comb begin
        capture     = 1'b0;
        rd_ack_next = 1'b0;
        if (state_reg == IDLE && RD_REQ) begin
            capture = 1'b1;
        end
        if (state_next == ACK) begin
            rd_ack_next = 1'b1;
        end
    end

    // DIR captures the pre-toggle filt_reg. When a toggle coincides with a
    // capture, the set of DIR_CHG takes priority so the change is not lost.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            rd_ack_reg  <= 1'b0;
            dir_reg     <= '0;
            dir_chg_reg <= 1'b0;
        end else begin
            rd_ack_reg <= rd_ack_next;
            if (capture) begin
                dir_reg <= filt_reg;
            end
            if (|filt_toggle) begin
                dir_chg_reg <= 1'b1;
            end else if (capture) begin
                dir_chg_reg <= 1'b0;
            end
        end
    end

    assign DIR     = dir_reg;
    assign RD_ACK  = rd_ack_reg;
    assign DIR_CHG = dir_chg_reg;

`ifdef DISC_MISCOMPARE_EN
    localparam int MW = (MISCMP_LIMIT > 1) ? $clog2(MISCMP_LIMIT + 1) : 1;

    logic [N-1:0] mis_set;
    logic [N-1:0] miscmp_reg;

    generate
        for (gi = 0; gi < N; gi++) begin : g_mis
            logic [MW-1:0] mcnt_reg;
            logic          disagree;

            assign disagree = (s2_a_reg[gi] ^ vote[gi]) | (s2_b_reg[gi] ^ vote[gi]) |
                              (s2_c_reg[gi] ^ vote[gi]);
            // The set is asserted on the edge the count reaches the limit and
            // on every edge while it stays saturated. A clear issued while
            // the fault persists therefore cannot hide the fault.
            assign mis_set[gi] = disagree && (mcnt_reg >= MW'(MISCMP_LIMIT - 1));

            always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
                if (SIM_RST) begin
                    mcnt_reg <= '0;
                end else if (!disagree) begin
                    mcnt_reg <= '0;
                end else if (mcnt_reg != MW'(MISCMP_LIMIT)) begin
                    mcnt_reg <= mcnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            miscmp_reg <= '0;
        end else begin
            miscmp_reg <= (miscmp_reg & ~{N{MISCMP_CLR}}) | mis_set;
        end
    end

    assign MISCMP = miscmp_reg;
`else
    logic unused_sink;
    assign unused_sink = MISCMP_CLR ^ (MISCMP_LIMIT > 0);
    assign MISCMP      = '0;
`endif

endmodule

// File: tb/tb_discrete_input_receivers.sv
// Testbench for discrete_input_receivers.
// The reference model works from the behavioural rules of the design:
//   - each input reaches the voter two edges after it is sampled;
//   - the vote is a count of ones >= 2;
//   - the filter tracks a run length of disagreeing samples;
//   - RD_ACK follows the request level, and a capture happens on its rising
//     edge.
// Directed sequences are followed by randomized traffic.
`timescale 1ns/1ps
module tb_discrete_input_receivers;

    localparam int N            = 4;
    localparam int DEBOUNCE     = 4;
    localparam int MISCMP_LIMIT = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] di_a, di_b, di_c;
    logic         rd_req;
    logic [N-1:0] dir;
    logic         rd_ack;
    logic         dir_chg;
    logic [N-1:0] miscmp;
    logic         mis_clr;

    int total = 0;
    int bad   = 0;

    discrete_input_receivers #(
        .N(N), .DEBOUNCE(DEBOUNCE), .MISCMP_LIMIT(MISCMP_LIMIT)
    ) u_dut (
        .SIM_CLK(clk), .SIM_RST(rst),
        .DI_A(di_a), .DI_B(di_b), .DI_C(di_c),
        .RD_REQ(rd_req), .DIR(dir), .RD_ACK(rd_ack), .DIR_CHG(dir_chg),
        .MISCMP(miscmp), .MISCMP_CLR(mis_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] p1 [3];
    logic [N-1:0] p2 [3];
    logic [N-1:0] m_filt, m_dir, m_mis;
    bit           m_ack, m_chg;
    int           run  [N];
    int           mrun [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            p1[k] = '0;
            p2[k] = '0;
        end
        m_filt = '0; m_dir = '0; m_mis = '0;
        m_ack = 1'b0; m_chg = 1'b0;
        for (int b = 0; b < N; b++) begin
            run[b]  = 0;
            mrun[b] = 0;
        end
    endtask

    // Advance the model by one clock edge, using the pre-edge inputs.
    task automatic model_edge();
        logic [N-1:0] v;
        logic [N-1:0] flips;
        logic [N-1:0] set;
        bit           cap;
        flips = '0;
        set   = '0;
        for (int b = 0; b < N; b++) begin
            int ones;
            ones = int'(p2[0][b]) + int'(p2[1][b]) + int'(p2[2][b]);
            v[b] = (ones >= 2);
            if (v[b] != m_filt[b]) begin
                run[b]++;
                if (run[b] == DEBOUNCE) begin
                    flips[b] = 1'b1;
                    run[b]   = 0;
                end
            end else begin
                run[b] = 0;
            end
`ifdef DISC_MISCOMPARE_EN
            if (ones != 0 && ones != 3) begin
                if (mrun[b] < MISCMP_LIMIT) mrun[b]++;
                if (mrun[b] == MISCMP_LIMIT) set[b] = 1'b1;
            end else begin
                mrun[b] = 0;
            end
`endif
        end
        cap = rd_req && !m_ack;
        if (cap) m_dir = m_filt;
        m_ack = rd_req;
        if (flips != '0) m_chg = 1'b1;
        else if (cap)    m_chg = 1'b0;
        m_filt = m_filt ^ flips;
`ifdef DISC_MISCOMPARE_EN
        m_mis = (mis_clr ? '0 : m_mis) | set;
`endif
        p2 = p1;
        p1[0] = di_a; p1[1] = di_b; p1[2] = di_c;
    endtask

    task automatic compare_all();
        chk("dir", dir, m_dir);
        chk("rd_ack", rd_ack, m_ack);
        chk("dir_chg", dir_chg, m_chg);
        chk("filt", u_dut.filt_reg, m_filt);
        chk("miscmp", miscmp, m_mis);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        di_a = a; di_b = b; di_c = c;
    endtask

    task automatic do_read(input logic [N-1:0] exp_dir);
        rd_req = 1'b1;
        tick();
        chk("read_dir", dir, exp_dir);
        chk("read_ack", rd_ack, 1'b1);
        $display("read: dir=%0h chg=%0b exp=%0h", dir, dir_chg, exp_dir);
        rd_req = 1'b0;
        tick();
        chk("read_ack_low", rd_ack, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; mis_clr = 1'b0;
        drive(4'hF, 4'hF, 4'hF);
        model_reset();

        // Reset state with all inputs high
        repeat (3) tick();
        chk("rst_dir", dir, 4'h0);
        chk("rst_ack", rd_ack, 1'b0);
        chk("rst_chg", dir_chg, 1'b0);
        chk("rst_mis", miscmp, 4'h0);

        // Release; the first sample is at the next edge (edge 0) and filt
        // must reach F at edge 5.
        rst = 1'b0;
        repeat (5) tick();
        chk("lat_edge4", u_dut.filt_reg, 4'h0);
        tick();
        chk("lat_edge5", u_dut.filt_reg, 4'hF);
        do_read(4'hF);

        // Glitch rejection
        drive(4'h0, 4'h0, 4'h0);
        repeat (8) tick();
        do_read(4'h0);
        drive(4'h2, 4'h2, 4'h2);
        repeat (3) tick();
        drive(4'h0, 4'h0, 4'h0);
        repeat (8) tick();
        chk("glitch3_filt", u_dut.filt_reg, 4'h0);
        chk("glitch3_chg", dir_chg, 1'b0);
        drive(4'h2, 4'h2, 4'h2);
        repeat (4) tick();
        drive(4'h0, 4'h0, 4'h0);
        repeat (10) tick();
        chk("glitch4_chg", dir_chg, 1'b1);
        do_read(4'h0);

        // Voting with channel C disagreeing on every bit
        drive(4'h5, 4'h5, 4'hA);
        repeat (12) tick();
        do_read(4'h5);
`ifdef DISC_MISCOMPARE_EN
        chk("mis_set", miscmp, 4'hF);
        mis_clr = 1'b1;
        tick();
        mis_clr = 1'b0;
        chk("mis_set_wins", miscmp, 4'hF);
`else
        chk("mis_off", miscmp, 4'h0);
`endif

        // Handshake; inputs change while in ACK
        rd_req = 1'b1;
        tick();
        chk("hs_ack_rise", rd_ack, 1'b1);
        drive(4'h3, 4'h3, 4'h3);
        repeat (8) tick();
        chk("hs_ack_hold", rd_ack, 1'b1);
        chk("hs_dir_hold", dir, 4'h5);
        rd_req = 1'b0;
        tick();
        chk("hs_ack_fall", rd_ack, 1'b0);
        chk("hs_dir_idle", dir, 4'h5);
        do_read(4'h3);

        // Filt toggle on the same edge that first samples RD_REQ
        drive(4'h7, 4'h7, 4'h7);
        repeat (5) tick();
        rd_req = 1'b1;
        tick();
        chk("sim_dir_old", dir, 4'h3);
        chk("sim_chg_set", dir_chg, 1'b1);
        chk("sim_filt_new", u_dut.filt_reg, 4'h7);
        rd_req = 1'b0;
        tick();
        do_read(4'h7);
        chk("sim_chg_clr", dir_chg, 1'b0);

        // Asynchronous reset between edges while in ACK
        rd_req = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_ack", rd_ack, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("async_recapture_ack", rd_ack, 1'b1);
        chk("async_recapture_dir", dir, 4'h0);
        rd_req = 1'b0;
        tick();

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            logic [N-1:0] w, x;
            int mode, hold;
            w    = N'($urandom);
            x    = N'($urandom);
            mode = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 8));
            case (mode)
                0: drive(w, w, w);
                1: drive(w, w, x);
                2: drive(x, w, w);
                default: drive(w, x, w);
            endcase
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
                mis_clr = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        mis_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
